// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter_pkg: shared encodings for the unified memory arbiter (rev 1.0)
// ============================================================================
package unified_mem_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter_if: pipeline (IF/MEM) and memory signals of the arbiter (rev 1.0)
// ============================================================================
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ready;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [2:0]        d_func3;
  logic              d_ready;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_func3;
  logic [31:0]       mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  // Arbiter side: consumes pipeline requests and memory read data.
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_func3, mem_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
    output mem_addr, mem_read, mem_write, mem_wdata, mem_func3, stall_if, stall_mem
  );

  // Pipeline + memory side.
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_func3, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
    input  mem_addr, mem_read, mem_write, mem_wdata, mem_func3, stall_if, stall_mem
  );

endinterface
`default_nettype wire

// File: rtl/arb_latency_counter.sv
`default_nettype none
// ============================================================================
// arb_latency_counter: loadable down-counter, tc_o flags the final count of 1 (rev 1.0)
// ============================================================================
module arb_latency_counter (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       load_i,
  input  wire logic [2:0] load_val_i,
  input  wire logic       en_i,
  output logic            tc_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == 3'd1);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter: IF/MEM arbiter for a fixed-latency unified memory (rev 1.0)
// ============================================================================
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input wire logic              clk,
  input wire logic              rst,
  unified_mem_arbiter_if.slave  bus
);

  state_e     state_q;
  owner_e     owner_q;
  logic       we_q;
  logic       cancel_q;
  logic [3:0] st_cnt_q;

  logic              w_if_elig;
  logic              w_idle;
  logic              w_d_win;
  logic              w_if_win;
  logic              w_grant;
  logic              w_tc;
  logic              w_done;
  logic              w_if_rvalid;
  logic              w_d_rvalid;
  logic [ADDR_W-1:0] w_mem_addr;

  // Everything is qualified by rst so the block is fully silent while held in reset.
  assign w_if_elig = bus.if_req & ~bus.if_flush;
  assign w_idle    = rst & (state_q == ST_IDLE);
  assign w_d_win   = w_idle & bus.d_req & (~w_if_elig | (st_cnt_q < 4'(STARVE_MAX)));
  assign w_if_win  = w_idle & w_if_elig & ~w_d_win;
  assign w_grant   = w_d_win | w_if_win;
  assign w_done    = rst & (state_q == ST_WAIT) & w_tc;

  arb_latency_counter u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_grant),
    .load_val_i (3'(MEM_LAT)),
    .en_i       (state_q == ST_WAIT),
    .tc_o       (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      cancel_q <= 1'b0;
      st_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_grant) begin
            state_q  <= ST_WAIT;
            owner_q  <= w_d_win ? OWN_D : OWN_IF;
            we_q     <= w_d_win & bus.d_we;
            cancel_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if ((owner_q == OWN_IF) && bus.if_flush) begin
            cancel_q <= 1'b1;
          end
          if (w_tc) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (w_if_win || !w_if_elig) begin
        st_cnt_q <= 4'd0;
      end else if (w_d_win && (st_cnt_q < 4'(STARVE_MAX))) begin
        st_cnt_q <= st_cnt_q + 4'd1;
      end
    end
  end

  // A flush landing in the response cycle itself also suppresses the fetch response.
  assign w_if_rvalid = w_done & (owner_q == OWN_IF) & ~cancel_q & ~bus.if_flush;
  assign w_d_rvalid  = w_done & (owner_q == OWN_D);
  assign w_mem_addr  = w_d_win ? bus.d_addr : (w_if_win ? bus.if_addr : '0);

  assign bus.if_ready  = w_if_win;
  assign bus.d_ready   = w_d_win;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_read  = w_if_win | (w_d_win & ~bus.d_we);
  assign bus.mem_write = w_d_win & bus.d_we;
  assign bus.mem_wdata = (w_d_win & bus.d_we) ? bus.d_wdata : 32'd0;
  assign bus.mem_func3 = w_d_win ? bus.d_func3 : (w_if_win ? FUNC3_WORD : 3'd0);

  assign bus.if_rvalid = w_if_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : 32'd0;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.d_rdata   = (w_d_rvalid & ~we_q) ? bus.mem_rdata : 32'd0;

  assign bus.stall_if  = rst & bus.if_req & ~w_if_rvalid & ~bus.if_flush;
  assign bus.stall_mem = rst & bus.d_req & ~w_d_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_unified_mem_arbiter: directed checks of the arbiter at MEM_LAT 1, 2 and 3 (rev 1.0)
// ============================================================================
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(10)) b1 ();
  unified_mem_arbiter_if #(.ADDR_W(10)) b2 ();
  unified_mem_arbiter_if #(.ADDR_W(10)) b3 ();

  unified_mem_arbiter #(.ADDR_W(10), .MEM_LAT(1), .STARVE_MAX(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
  unified_mem_arbiter #(.ADDR_W(10), .MEM_LAT(2), .STARVE_MAX(4)) u2 (.clk(clk), .rst(rst), .bus(b2));
  unified_mem_arbiter #(.ADDR_W(10), .MEM_LAT(3), .STARVE_MAX(4)) u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int got_seq [12];

  initial begin
    int ng;
    int last;
    int min_gap;
    logic both;
    logic saw;

    b1.if_req = 0; b1.if_addr = '0; b1.if_flush = 0; b1.d_req = 0; b1.d_we = 0;
    b1.d_addr = '0; b1.d_wdata = '0; b1.d_func3 = 3'b010; b1.mem_rdata = '0;
    b2.if_req = 0; b2.if_addr = '0; b2.if_flush = 0; b2.d_req = 0; b2.d_we = 0;
    b2.d_addr = '0; b2.d_wdata = '0; b2.d_func3 = 3'b010; b2.mem_rdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.if_flush = 0; b3.d_req = 0; b3.d_we = 0;
    b3.d_addr = '0; b3.d_wdata = '0; b3.d_func3 = 3'b010; b3.mem_rdata = '0;

    // 1: reset with both requests high, then release
    b1.d_req = 1; b1.if_req = 1; b1.d_addr = 10'h020; b1.mem_rdata = 32'h1111_1111;
    smp();
    chk("rst_d_ready",   32'(b1.d_ready),   0);
    chk("rst_if_ready",  32'(b1.if_ready),  0);
    chk("rst_mem_read",  32'(b1.mem_read),  0);
    chk("rst_mem_write", 32'(b1.mem_write), 0);
    chk("rst_stall_if",  32'(b1.stall_if),  0);
    chk("rst_stall_mem", 32'(b1.stall_mem), 0);
    chk("rst_d_rvalid",  32'(b1.d_rvalid),  0);
    step();
    rst = 1;
    smp();
    chk("t1_d_ready",   32'(b1.d_ready),   1);
    chk("t1_if_ready",  32'(b1.if_ready),  0);
    chk("t1_mem_read",  32'(b1.mem_read),  1);
    chk("t1_mem_addr",  32'(b1.mem_addr),  32'h020);
    chk("t1_stall_mem", 32'(b1.stall_mem), 1);
    step(); smp();
    chk("t1_d_rvalid",  32'(b1.d_rvalid),  1);
    chk("t1_d_rdata",   b1.d_rdata,        32'h1111_1111);
    chk("t1_d_ready2",  32'(b1.d_ready),   0);
    chk("t1_stall_mem2", 32'(b1.stall_mem), 0);
    step();
    b1.d_req = 0; b1.if_req = 0;
    step(); step();

    // 2: fetch only at MEM_LAT=2
    b2.if_req = 1; b2.if_addr = 10'h004; b2.mem_rdata = 32'h0000_0013;
    smp();
    chk("t2_if_ready_T0",  32'(b2.if_ready),  1);
    chk("t2_mem_read_T0",  32'(b2.mem_read),  1);
    chk("t2_mem_addr_T0",  32'(b2.mem_addr),  32'h004);
    chk("t2_mem_func3_T0", 32'(b2.mem_func3), 32'h2);
    chk("t2_stall_if_T0",  32'(b2.stall_if),  1);
    step(); smp();
    chk("t2_if_ready_T1",  32'(b2.if_ready),  0);
    chk("t2_mem_read_T1",  32'(b2.mem_read),  0);
    chk("t2_if_rvalid_T1", 32'(b2.if_rvalid), 0);
    chk("t2_stall_if_T1",  32'(b2.stall_if),  1);
    step(); smp();
    chk("t2_if_rvalid_T2", 32'(b2.if_rvalid), 1);
    chk("t2_if_rdata_T2",  b2.if_rdata,       32'h0000_0013);
    chk("t2_stall_if_T2",  32'(b2.stall_if),  0);
    step();
    b2.if_req = 0;
    step();

    // 3: store
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 10'h100; b1.d_wdata = 32'hDEAD_BEEF;
    b1.d_func3 = 3'b010; b1.mem_rdata = 32'h5555_5555;
    smp();
    chk("t3_mem_write", 32'(b1.mem_write), 1);
    chk("t3_mem_read",  32'(b1.mem_read),  0);
    chk("t3_mem_addr",  32'(b1.mem_addr),  32'h100);
    chk("t3_mem_wdata", b1.mem_wdata,      32'hDEAD_BEEF);
    chk("t3_mem_func3", 32'(b1.mem_func3), 32'h2);
    step(); smp();
    chk("t3_mem_write2", 32'(b1.mem_write), 0);
    chk("t3_d_rvalid",   32'(b1.d_rvalid),  1);
    chk("t3_d_rdata",    b1.d_rdata,        32'h0);
    step();
    b1.d_req = 0; b1.d_we = 0;
    step();

    // 4: continuous contention, starvation bound
    b1.d_addr = 10'h010; b1.if_addr = 10'h008; b1.d_req = 1; b1.if_req = 1;
    ng = 0; last = -10; min_gap = 100; both = 0;
    for (int c = 0; c < 22; c++) begin
      smp();
      if (b1.d_ready && b1.if_ready) both = 1;
      if (b1.d_ready || b1.if_ready) begin
        if (ng < 12) got_seq[ng] = b1.if_ready ? 1 : 0;
        if (c - last < min_gap) min_gap = c - last;
        last = c;
        ng++;
      end
      step();
    end
    b1.d_req = 0; b1.if_req = 0;
    chk("t4_grant_count", 32'(ng), 11);
    chk("t4_min_gap", 32'(min_gap), 2);
    chk("t4_dual_grant", 32'(both), 0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_grant%0d", k), 32'(got_seq[k]), 32'(exp_seq[k]));
    end
    step(); step();

    // 5: flush an in-flight fetch at MEM_LAT=3, data waits behind it
    b3.if_req = 1; b3.if_addr = 10'h040; b3.mem_rdata = 32'h0000_0077;
    b3.d_addr = 10'h080; b3.d_we = 0;
    saw = 0;
    smp();
    chk("t5_if_ready", 32'(b3.if_ready), 1);
    step();
    b3.if_flush = 1; b3.if_req = 0; b3.d_req = 1;
    smp();
    saw = saw | b3.if_rvalid;
    chk("t5_d_ready_T1", 32'(b3.d_ready), 0);
    step();
    b3.if_flush = 0;
    smp();
    saw = saw | b3.if_rvalid;
    step(); smp();
    saw = saw | b3.if_rvalid;
    chk("t5_d_ready_T3", 32'(b3.d_ready), 0);
    step(); smp();
    saw = saw | b3.if_rvalid;
    chk("t5_d_ready_T4", 32'(b3.d_ready), 1);
    chk("t5_mem_addr_T4", 32'(b3.mem_addr), 32'h080);
    step(); smp(); saw = saw | b3.if_rvalid;
    step(); smp(); saw = saw | b3.if_rvalid;
    step(); smp(); saw = saw | b3.if_rvalid;
    chk("t5_d_rvalid_T7", 32'(b3.d_rvalid), 1);
    chk("t5_d_rdata_T7", b3.d_rdata, 32'h0000_0077);
    chk("t5_if_rvalid_never", 32'(saw), 0);
    step();
    b3.d_req = 0;
    step();

    // 6: reset during the wait of a load, then re-present it
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 10'h044; b1.mem_rdata = 32'hCAFE_F00D;
    smp();
    chk("t6_d_ready", 32'(b1.d_ready), 1);
    step();
    rst = 0;
    smp();
    chk("t6_d_rvalid_rst", 32'(b1.d_rvalid), 0);
    chk("t6_d_ready_rst", 32'(b1.d_ready), 0);
    step(); smp();
    chk("t6_d_rvalid_rst2", 32'(b1.d_rvalid), 0);
    step();
    rst = 1;
    smp();
    chk("t6_d_ready_again", 32'(b1.d_ready), 1);
    step(); smp();
    chk("t6_d_rvalid", 32'(b1.d_rvalid), 1);
    chk("t6_d_rdata", b1.d_rdata, 32'hCAFE_F00D);
    step();
    b1.d_req = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates the single unified instruction/data memory between the fetch stage (IF) and the data stage (MEM) of the pipelined RV32 core. It replaces clock-phase address muxing with a request/accept/response handshake against a memory of fixed read latency. It produces per-stage stall signals for the pipeline registers and supports cancelling an in-flight fetch when a branch redirects the PC. It sits between the pipeline and the memory: IF and MEM drive it, and it drives the memory.

Parameters:
ADDR_W, 10, memory byte-address width
MEM_LAT, 1, cycles from memory issue to valid mem_rdata (range 1..7)
STARVE_MAX, 4, consecutive data grants allowed while a fetch waits (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_rvalid or if_flush
if_addr  in  ADDR_W  fetch address
if_flush  in  1  cancel the pending or in-flight fetch (branch taken)
if_ready  out  1  fetch accepted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  32  instruction word
d_req  in  1  data request; held stable until d_rvalid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  32  store data
d_func3  in  3  access size/sign code, passed through to memory
d_ready  out  1  data access accepted this cycle
d_rvalid  out  1  one-cycle completion pulse (loads and stores)
d_rdata  out  32  load data; 0 for stores
mem_addr  out  ADDR_W  memory address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_wdata  out  32  memory write data
mem_func3  out  3  memory func3 (fetch drives 3'b010)
mem_rdata  in  32  memory read data
stall_if  out  1  if_req & ~if_rvalid & ~if_flush
stall_mem  out  1  d_req & ~d_rvalid

Behaviour:
- States: IDLE and WAIT, with owner register (IF or D), latency counter lat_cnt (3 bits), starve counter st_cnt (4 bits), and cancel flag.
- Reset (rst=0, asynchronous): state IDLE; all counters and flags cleared; every registered output is 0. Any in-flight access is abandoned and produces no rvalid.
- IDLE: eligible fetch = if_req & ~if_flush.
  - Winner is D if d_req and (no eligible fetch or st_cnt < STARVE_MAX); otherwise IF if a fetch is eligible.
  - In the same cycle, the block drives mem_* combinationally from the winner and pulses the winner's ready signal.
  - Fetch drives mem_read=1. Data drives mem_read=~d_we and mem_write=d_we.
  - Then go to WAIT with lat_cnt = MEM_LAT.
- Starve counter:
  - Increments on a D grant while a fetch is eligible (saturates at STARVE_MAX).
  - Clears on an IF grant or when no fetch is eligible.
- WAIT: mem_read and mem_write are 0; no request is accepted. lat_cnt decrements each cycle.
  - When lat_cnt = 1, the owner's rvalid pulses and rdata samples mem_rdata (0 for stores). Then return to IDLE.
  - Latency from accept to rvalid is exactly MEM_LAT cycles. Throughput is one access per MEM_LAT+1 cycles.
- if_flush:
  - In IDLE it masks the fetch request.
  - During WAIT with owner IF, it sets the cancel flag. The response slot still elapses, but if_rvalid stays 0. The flag clears on return to IDLE.
  - It has no effect on data accesses.
- Simultaneous if_req and d_req with st_cnt=0: D wins.
- Outputs for the non-owner requester remain 0 throughout.

Decomposition:
- Shared package holds: state encoding (ST_IDLE, ST_WAIT), owner encoding (OWN_IF, OWN_D), FUNC3_WORD = 3'b010.
- One natural sub-module, arb_latency_counter: loadable down-counter with terminal-count output, used for lat_cnt.

Test Plan:
1. Reset with both requests high, rst=0 → all outputs 0. On release with MEM_LAT=1, d_ready pulses in the first cycle and d_rvalid pulses 1 cycle later.
2. Fetch only, if_addr=0x004, mem_rdata=0x00000013, MEM_LAT=2 → if_ready at T0, mem_read=1 at T0, if_rvalid with if_rdata=0x00000013 at T2, stall_if high T0–T1.
3. Store, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_func3=3'b010 → mem_write=1 with matching addr/data/func3 for one cycle; d_rvalid one cycle later with d_rdata=0.
4. Continuous d_req and if_req, STARVE_MAX=4, MEM_LAT=1 → grant order D,D,D,D,IF,D,D,D,D,IF; no two grants closer than 2 cycles.
5. Fetch accepted, then if_flush=1 during WAIT (MEM_LAT=3) → if_rvalid never asserts. A d_req pending during WAIT is granted on the first IDLE cycle after 3 cycles.
6. rst asserted during WAIT of a load → d_rvalid never pulses. After release, the re-presented load completes normally with correct d_rdata.
